proc_ctrl: RTL and testbench
============================

PROC_CTRL -- requirements
Module: proc_ctrl

Interface
REQ-001 SHALL have parameter MEM_WAIT_MAX, default 15, the maximum cycles to wait for mem_ready before a bus error.
REQ-002 SHALL have port CLOCK_50  in  1  system clock; all state changes on its rising edge.
REQ-003 SHALL have port Resetn  in  1  asynchronous active-low reset.
REQ-004 SHALL have port Run  in  1  start/continue instruction execution.
REQ-005 SHALL have port IR  in  16  instruction register contents: [15:13] opcode, [12] imm flag, [11:9] rX/cond, [8:0] imm or [2:0] rY.
REQ-006 SHALL have port flags  in  3  {c, n, z} from the datapath flag register.
REQ-007 SHALL have port mem_ready  in  1  memory/IO access complete.
REQ-008 SHALL have port Sel  out  4  bus source select: R0-R7, DIN, IMM, IMM_HI (imm<<8), G.
REQ-009 SHALL have port Rin  out  8  one-hot register write enables, with bit 7 = pc.
REQ-010 SHALL have port ctl  out  9  {IRin, Ain, Gin, AddSub, ALUand, ADDRin, DOUTin, W_D, pc_incr}.
REQ-011 SHALL have port flags_we  out  1  load the flag register from the ALU.
REQ-012 SHALL have port Done  out  1  one-cycle pulse in an instruction's last cycle.
REQ-013 SHALL have port err  out  1  sticky bus timeout flag.

Function
REQ-014 SHALL use states IDLE, FETCH, WAIT_I, T1, T2, T3, WAIT_D, ERR.
REQ-015 SHALL leave IDLE for FETCH when Run=1; otherwise SHALL remain in IDLE.
REQ-016 SHALL, in FETCH: Sel=R7, ADDRin=1, pc_incr=1, next state WAIT_I.
REQ-017 SHALL, in WAIT_I: when mem_ready=1, assert IRin and go to T1; when mem_ready=0, hold.
REQ-018 SHALL execute mv (op 0) in T1: Sel=rY or IMM, Rin[rX]=1, Done.
REQ-019 SHALL execute mvt (op 1) in T1: Sel=IMM_HI, Rin[rX]=1, Done.
REQ-020 SHALL execute add/sub/and (ops 2/3/6) as: T1 Sel=rX, Ain; T2 Sel=rY or IMM, Gin, AddSub (sub) or ALUand (and), flags_we; T3 Sel=G, Rin[rX], Done.
REQ-021 SHALL execute ld (op 4) as: T1 Sel=rY, ADDRin; WAIT_D until mem_ready; then T3 Sel=DIN, Rin[rX], Done.
REQ-022 SHALL execute st (op 5) as: T1 Sel=rY, ADDRin; T2 Sel=rX, DOUTin, W_D; WAIT_D until mem_ready, Done on the mem_ready cycle.
REQ-023 SHALL execute b{cond} (op 7) with cond in IR[11:9]: 0 always, 1 eq(z), 2 ne(!z), 3 cc(!c), 4 cs(c), 5 pl(!n), 6 mi(n).
REQ-024 SHALL, for a taken branch: T1 Sel=R7, Ain; T2 Sel=IMM, Gin (add); T3 Sel=G, Rin[7], Done.
REQ-025 SHALL, for a not-taken branch: assert Done in T1 and make no register writes.
REQ-026 SHALL, after Done, go to FETCH if Run=1, else IDLE.
REQ-027 SHALL keep all outputs other than those listed for a state at 0 in that state; Rin SHALL be one-hot or zero.
REQ-028 SHALL count cycles spent in WAIT_I/WAIT_D, clearing the count on state entry.
REQ-029 SHALL, on reaching MEM_WAIT_MAX cycles without mem_ready, set err and enter ERR.
REQ-030 SHALL leave ERR only on reset.
REQ-031 SHALL complete an instruction already in progress when Run drops mid-instruction; Run is sampled only at IDLE exit and after Done.
REQ-032 SHALL treat mem_ready asserted in the same cycle as the timeout count as success.

Reset
REQ-033 SHALL, when Resetn=0, immediately force state IDLE, counter 0, err 0, and Sel/Rin/ctl/flags_we/Done all 0, independent of the clock.

Configuration
REQ-034 SHALL, with PROC_CTRL_BL_EN defined, treat cond 7 as bl: T1 Sel=R7, Rin[6], Ain; then T2/T3 as for a taken branch.
REQ-035 SHALL, without PROC_CTRL_BL_EN defined, treat cond 7 as never taken.

Structure
REQ-036 SHALL place the opcode, Sel code, cond code and state encodings in shared package proc_pkg.
REQ-037 SHALL implement condition evaluation (cond, flags -> taken) as sub-module proc_cond_eval.

Verification
REQ-038 SHALL cover: reset, Run=1, mem_ready tied 1 -> FETCH, WAIT_I, T1 sequence; IR=mv r0,#5 (0x1005) -> Rin=0x01, Sel=IMM, Done in cycle 3.
REQ-039 SHALL cover: IR=add r1,r2 (0x4202) -> T1 Sel=R1 Ain, T2 Sel=R2 Gin flags_we, T3 Sel=G Rin=0x02, Done.
REQ-040 SHALL cover: ld with mem_ready delayed 4 cycles -> 4 cycles in WAIT_D, then Sel=DIN; a 16-cycle delay -> err=1 and state ERR.
REQ-041 SHALL cover: beq with z=0 -> Done in T1 with Rin=0; beq with z=1 -> Rin=0x80 in T3.
REQ-042 SHALL cover: Resetn low mid-ld -> all outputs 0 immediately; after release -> IDLE until Run=1.
REQ-043 SHALL cover: cond 7 -> Rin=0x40 in T1 with PROC_CTRL_BL_EN defined; Done in T1 with no writes without it.

Source files
------------

// File: rtl/proc_pkg.sv
// -----------------------------------------------------------------------------
// proc_pkg -- shared encodings for the processor control unit.
//   Opcodes (IR[15:13]), bus source select codes (Sel), branch condition
//   codes (IR[11:9] of op 7), controller state encodings, bit positions in
//   the ctl control word and a helper mapping a register number to its Sel.
// -----------------------------------------------------------------------------
package proc_pkg;

  typedef enum logic [2:0] {
    OP_MV  = 3'd0,
    OP_MVT = 3'd1,
    OP_ADD = 3'd2,
    OP_SUB = 3'd3,
    OP_LD  = 3'd4,
    OP_ST  = 3'd5,
    OP_AND = 3'd6,
    OP_B   = 3'd7
  } opcode_t;

  // Bus source select; R0..R7 occupy codes 0..7 so a register number maps
  // straight onto its select code.
  typedef enum logic [3:0] {
    SEL_R0     = 4'd0,
    SEL_R7     = 4'd7,
    SEL_DIN    = 4'd8,
    SEL_IMM    = 4'd9,
    SEL_IMM_HI = 4'd10,
    SEL_G      = 4'd11
  } sel_t;

  typedef enum logic [2:0] {
    COND_AL = 3'd0,
    COND_EQ = 3'd1,
    COND_NE = 3'd2,
    COND_CC = 3'd3,
    COND_CS = 3'd4,
    COND_PL = 3'd5,
    COND_MI = 3'd6,
    COND_BL = 3'd7
  } cond_t;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_FETCH  = 3'd1,
    ST_WAIT_I = 3'd2,
    ST_T1     = 3'd3,
    ST_T2     = 3'd4,
    ST_T3     = 3'd5,
    ST_WAIT_D = 3'd6,
    ST_ERR    = 3'd7
  } proc_state_t;

  // ctl = {IRin, Ain, Gin, AddSub, ALUand, ADDRin, DOUTin, W_D, pc_incr}
  localparam int CTL_IRIN   = 8;
  localparam int CTL_AIN    = 7;
  localparam int CTL_GIN    = 6;
  localparam int CTL_ADDSUB = 5;
  localparam int CTL_ALUAND = 4;
  localparam int CTL_ADDRIN = 3;
  localparam int CTL_DOUTIN = 2;
  localparam int CTL_WD     = 1;
  localparam int CTL_PCINCR = 0;

  // Rin bit positions of the link register and the program counter
  localparam int RIN_LR = 6;
  localparam int RIN_PC = 7;

  function automatic logic [3:0] reg_sel(input logic [2:0] r);
    return {1'b0, r};
  endfunction

endpackage

// File: rtl/proc_ctrl_if.sv
// -----------------------------------------------------------------------------
// proc_ctrl_if -- bundle between the control unit and the datapath/memory.
//   Run, IR, flags, mem_ready : datapath/memory -> controller
//   Sel, Rin, ctl, flags_we   : controller -> datapath
//   Done, err                 : controller status
//   state                     : current controller state (observation only)
// Modports: master = controller side, slave = datapath side.
// -----------------------------------------------------------------------------
interface proc_ctrl_if;

  logic                   Run;
  logic [15:0]            IR;
  logic [2:0]             flags;      // {c, n, z}
  logic                   mem_ready;
  logic [3:0]             Sel;
  logic [7:0]             Rin;
  logic [8:0]             ctl;
  logic                   flags_we;
  logic                   Done;
  logic                   err;
  proc_pkg::proc_state_t  state;

  modport master (
    input  Run, IR, flags, mem_ready,
    output Sel, Rin, ctl, flags_we, Done, err, state
  );

  modport slave (
    output Run, IR, flags, mem_ready,
    input  Sel, Rin, ctl, flags_we, Done, err, state
  );

endinterface

// File: rtl/proc_cond_eval.sv
// -----------------------------------------------------------------------------
// proc_cond_eval -- branch condition evaluation.
//   i_cond  : condition code from IR[11:9]
//   i_flags : {c, n, z} from the datapath flag register
//   o_taken : 1 when the branch should be taken
// Build option PROC_CTRL_BL_EN: when defined, cond 7 (bl) is always taken;
// otherwise cond 7 is never taken.
// -----------------------------------------------------------------------------
module proc_cond_eval
  import proc_pkg::*;
(
  input  logic [2:0] i_cond,
  input  logic [2:0] i_flags,
  output logic       o_taken
);

  logic w_c;
  logic w_n;
  logic w_z;

  assign w_c = i_flags[2];
  assign w_n = i_flags[1];
  assign w_z = i_flags[0];

  always_comb begin
    o_taken = 1'b0;
    case (i_cond)
      COND_AL: o_taken = 1'b1;
      COND_EQ: o_taken = w_z;
      COND_NE: o_taken = ~w_z;
      COND_CC: o_taken = ~w_c;
      COND_CS: o_taken = w_c;
      COND_PL: o_taken = ~w_n;
      COND_MI: o_taken = w_n;
`ifdef PROC_CTRL_BL_EN
      COND_BL: o_taken = 1'b1;
`else
      COND_BL: o_taken = 1'b0;
`endif
      default: o_taken = 1'b0;
    endcase
  end

endmodule

// File: rtl/proc_ctrl.sv
// -----------------------------------------------------------------------------
// proc_ctrl -- multi-cycle control unit for a 16-bit processor.
//   CLOCK_50 : system clock, all state changes on the rising edge
//   Resetn   : asynchronous active-low reset
//   bus      : proc_ctrl_if.master (Run, IR, flags, mem_ready in;
//              Sel, Rin, ctl, flags_we, Done, err, state out)
// Parameter MEM_WAIT_MAX: cycles allowed in WAIT_I/WAIT_D without mem_ready
// before the sticky bus error is raised and the controller parks in ERR.
// Build option PROC_CTRL_BL_EN: branch cond 7 becomes bl (link into r6).
// Outputs are decoded from the state register, so an asserted reset forces
// them to zero without waiting for a clock edge.
// -----------------------------------------------------------------------------
module proc_ctrl
  import proc_pkg::*;
#(
  parameter int MEM_WAIT_MAX = 15
) (
  input  logic        CLOCK_50,
  input  logic        Resetn,
  proc_ctrl_if.master bus
);

  localparam int CW = (MEM_WAIT_MAX > 1) ? $clog2(MEM_WAIT_MAX) : 1;

  proc_state_t r_state;
  proc_state_t w_state_next;
  logic [CW-1:0] r_wait_cnt;
  logic [CW-1:0] w_cnt_next;
  logic          r_err;

  logic [3:0] w_sel;
  logic [7:0] w_rin;
  logic [8:0] w_ctl;
  logic       w_flags_we;
  logic       w_done;

  // instruction fields
  opcode_t    w_op;
  logic       w_imm;
  logic [2:0] w_rx;
  logic [2:0] w_ry;
  logic [3:0] w_src_sel;
  logic [7:0] w_rx_onehot;
  logic       w_taken;
  logic       w_is_bl;
  logic       w_in_wait;
  logic       w_cnt_last;
  logic       w_unused;

  assign w_op      = opcode_t'(bus.IR[15:13]);
  assign w_imm     = bus.IR[12];
  assign w_rx      = bus.IR[11:9];
  assign w_ry      = bus.IR[2:0];
  assign w_src_sel = w_imm ? SEL_IMM : reg_sel(w_ry);
  // the immediate value itself is consumed by the datapath, not here
  assign w_unused  = ^bus.IR[8:3];

  genvar gi;
  generate
    for (gi = 0; gi < 8; gi++) begin : g_rx_dec
      assign w_rx_onehot[gi] = (w_rx == 3'(gi));
    end
  endgenerate

  proc_cond_eval u_cond_eval (
    .i_cond  (w_rx),
    .i_flags (bus.flags),
    .o_taken (w_taken)
  );

`ifdef PROC_CTRL_BL_EN
  assign w_is_bl = (w_rx == COND_BL);
`else
  assign w_is_bl = 1'b0;
`endif

  assign w_in_wait  = (r_state == ST_WAIT_I) || (r_state == ST_WAIT_D);
  // this is the last wait cycle allowed; mem_ready here still counts
  assign w_cnt_last = (r_wait_cnt == CW'(MEM_WAIT_MAX - 1));

  always_comb begin
    w_state_next = r_state;
    w_sel        = SEL_R0;
    w_rin        = '0;
    w_ctl        = '0;
    w_flags_we   = 1'b0;
    w_done       = 1'b0;

    case (r_state)
      ST_IDLE: begin
        if (bus.Run) w_state_next = ST_FETCH;
      end

      ST_FETCH: begin
        w_sel              = SEL_R7;
        w_ctl[CTL_ADDRIN]  = 1'b1;
        w_ctl[CTL_PCINCR]  = 1'b1;
        w_state_next       = ST_WAIT_I;
      end

      ST_WAIT_I: begin
        if (bus.mem_ready) begin
          w_ctl[CTL_IRIN] = 1'b1;
          w_state_next    = ST_T1;
        end else if (w_cnt_last) begin
          w_state_next = ST_ERR;
        end
      end

      ST_T1: begin
        case (w_op)
          OP_MV: begin
            w_sel  = w_src_sel;
            w_rin  = w_rx_onehot;
            w_done = 1'b1;
          end
          OP_MVT: begin
            w_sel  = SEL_IMM_HI;
            w_rin  = w_rx_onehot;
            w_done = 1'b1;
          end
          OP_ADD, OP_SUB, OP_AND: begin
            w_sel          = reg_sel(w_rx);
            w_ctl[CTL_AIN] = 1'b1;
            w_state_next   = ST_T2;
          end
          OP_LD: begin
            w_sel             = reg_sel(w_ry);
            w_ctl[CTL_ADDRIN] = 1'b1;
            w_state_next      = ST_WAIT_D;
          end
          OP_ST: begin
            w_sel             = reg_sel(w_ry);
            w_ctl[CTL_ADDRIN] = 1'b1;
            w_state_next      = ST_T2;
          end
          OP_B: begin
            if (w_taken) begin
              // bl saves the return address (current pc) into r6 here
              w_sel          = SEL_R7;
              w_ctl[CTL_AIN] = 1'b1;
              w_rin[RIN_LR]  = w_is_bl;
              w_state_next   = ST_T2;
            end else begin
              w_done = 1'b1;
            end
          end
          default: w_state_next = ST_IDLE;
        endcase
      end

      ST_T2: begin
        case (w_op)
          OP_ADD, OP_SUB, OP_AND: begin
            w_sel             = w_src_sel;
            w_ctl[CTL_GIN]    = 1'b1;
            w_ctl[CTL_ADDSUB] = (w_op == OP_SUB);
            w_ctl[CTL_ALUAND] = (w_op == OP_AND);
            w_flags_we        = 1'b1;
            w_state_next      = ST_T3;
          end
          OP_ST: begin
            w_sel             = reg_sel(w_rx);
            w_ctl[CTL_DOUTIN] = 1'b1;
            w_ctl[CTL_WD]     = 1'b1;
            w_state_next      = ST_WAIT_D;
          end
          OP_B: begin
            // pc + offset
            w_sel          = SEL_IMM;
            w_ctl[CTL_GIN] = 1'b1;
            w_state_next   = ST_T3;
          end
          default: w_state_next = ST_IDLE;
        endcase
      end

      ST_T3: begin
        case (w_op)
          OP_ADD, OP_SUB, OP_AND: begin
            w_sel  = SEL_G;
            w_rin  = w_rx_onehot;
            w_done = 1'b1;
          end
          OP_B: begin
            w_sel         = SEL_G;
            w_rin[RIN_PC] = 1'b1;
            w_done        = 1'b1;
          end
          OP_LD: begin
            w_sel  = SEL_DIN;
            w_rin  = w_rx_onehot;
            w_done = 1'b1;
          end
          default: w_state_next = ST_IDLE;
        endcase
      end

      ST_WAIT_D: begin
        if (bus.mem_ready) begin
          // a store finishes as soon as memory accepts the write
          if (w_op == OP_ST) w_done = 1'b1;
          else               w_state_next = ST_T3;
        end else if (w_cnt_last) begin
          w_state_next = ST_ERR;
        end
      end

      ST_ERR: w_state_next = ST_ERR;

      default: w_state_next = ST_IDLE;
    endcase

    // Run is only looked at here and at IDLE exit
    if (w_done) w_state_next = bus.Run ? ST_FETCH : ST_IDLE;
  end

  // wait counter restarts on every entry into a wait state
  always_comb begin
    w_cnt_next = '0;
    if (w_in_wait && (w_state_next == r_state)) w_cnt_next = r_wait_cnt + CW'(1);
  end

  always_ff @(posedge CLOCK_50 or negedge Resetn) begin
    if (!Resetn) begin
      r_state    <= ST_IDLE;
      r_wait_cnt <= '0;
      r_err      <= 1'b0;
    end else begin
      r_state    <= w_state_next;
      r_wait_cnt <= w_cnt_next;
      if (w_state_next == ST_ERR) r_err <= 1'b1;
    end
  end

  assign bus.Sel      = w_sel;
  assign bus.Rin      = w_rin;
  assign bus.ctl      = w_ctl;
  assign bus.flags_we = w_flags_we;
  assign bus.Done     = w_done;
  assign bus.err      = r_err;
  assign bus.state    = r_state;

endmodule

// File: tb/tb_proc_ctrl.sv
// -----------------------------------------------------------------------------
// tb_proc_ctrl -- scoreboard bench for proc_ctrl.
//   The stimulus process drives inputs just after each rising edge and queues
//   the hand-computed outputs expected for that cycle; the monitor pops and
//   compares on the falling edge.
// -----------------------------------------------------------------------------
module tb_proc_ctrl;
  import proc_pkg::*;

  logic clk    = 1'b0;
  logic resetn = 1'b0;
  always #5 clk = ~clk;

  proc_ctrl_if bus ();

  proc_ctrl #(.MEM_WAIT_MAX(15)) dut (
    .CLOCK_50 (clk),
    .Resetn   (resetn),
    .bus      (bus)
  );

  typedef struct {
    string       nm;
    proc_state_t st;
    logic [3:0]  sel;
    logic [7:0]  rin;
    logic [8:0]  ctl;
    logic        fwe;
    logic        done;
    logic        err;
  } exp_t;

  exp_t sb_q[$];
  exp_t mon_e;
  int   checks   = 0;
  int   failures = 0;

  // ---------------- monitor ----------------
  always @(negedge clk) begin
    if (sb_q.size() > 0) begin
      mon_e = sb_q.pop_front();
      checks++;
      if (bus.state !== mon_e.st || bus.Sel !== mon_e.sel || bus.Rin !== mon_e.rin ||
          bus.ctl !== mon_e.ctl || bus.flags_we !== mon_e.fwe ||
          bus.Done !== mon_e.done || bus.err !== mon_e.err) begin
        failures++;
        $display("FAIL %s: got st=%0d sel=%0d rin=%02h ctl=%03h fwe=%b done=%b err=%b; want st=%0d sel=%0d rin=%02h ctl=%03h fwe=%b done=%b err=%b",
                 mon_e.nm, bus.state, bus.Sel, bus.Rin, bus.ctl, bus.flags_we, bus.Done, bus.err,
                 mon_e.st, mon_e.sel, mon_e.rin, mon_e.ctl, mon_e.fwe, mon_e.done, mon_e.err);
      end else if (mon_e.done) begin
        $display("txn %s done ok", mon_e.nm);
      end
    end
  end

  // ---------------- stimulus helpers ----------------
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk_cyc(input string nm, input proc_state_t st, input logic [3:0] sel,
                         input logic [7:0] rin, input logic [8:0] ctl, input logic fwe,
                         input logic done, input logic err);
    exp_t e;
    e.nm = nm; e.st = st; e.sel = sel; e.rin = rin; e.ctl = ctl;
    e.fwe = fwe; e.done = done; e.err = err;
    sb_q.push_back(e);
    tick();
  endtask

  task automatic chk0(input string nm, input proc_state_t st, input logic err);
    chk_cyc(nm, st, 4'd0, 8'h00, 9'h000, 1'b0, 1'b0, err);
  endtask

  // in IDLE: raise Run, expect this cycle still idle
  task automatic start();
    bus.Run = 1'b1;
    chk0("idle_exit", ST_IDLE, 1'b0);
  endtask

  // in FETCH: expect fetch, then WAIT_I with immediate mem_ready
  task automatic fetch(input logic [15:0] ir);
    bus.mem_ready = 1'b1;
    chk_cyc("fetch", ST_FETCH, 4'd7, 8'h00, 9'h009, 1'b0, 1'b0, 1'b0);
    bus.IR = ir;
    chk_cyc("wait_i", ST_WAIT_I, 4'd0, 8'h00, 9'h100, 1'b0, 1'b0, 1'b0);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached, want completion");
    $fatal(1, "watchdog");
  end

  // ---------------- stimulus ----------------
  initial begin
    bus.Run = 1'b0; bus.IR = 16'h0000; bus.flags = 3'b000; bus.mem_ready = 1'b0;
    repeat (2) @(posedge clk);
    #1 resetn = 1'b1;

    chk0("rst_idle", ST_IDLE, 1'b0);
    chk0("idle_hold", ST_IDLE, 1'b0);

    // mv r0,#5
    start(); fetch(16'h1005);
    bus.Run = 1'b0;
    chk_cyc("mv_t1", ST_T1, 4'd9, 8'h01, 9'h000, 1'b0, 1'b1, 1'b0);
    chk0("mv_idle", ST_IDLE, 1'b0);

    // add r1,r2 -> sub r3,#1 -> and r4,r5 back to back
    start(); fetch(16'h4202);
    chk_cyc("add_t1", ST_T1, 4'd1, 8'h00, 9'h080, 1'b0, 1'b0, 1'b0);
    chk_cyc("add_t2", ST_T2, 4'd2, 8'h00, 9'h040, 1'b1, 1'b0, 1'b0);
    chk_cyc("add_t3", ST_T3, 4'd11, 8'h02, 9'h000, 1'b0, 1'b1, 1'b0);
    fetch(16'h7601);
    chk_cyc("sub_t1", ST_T1, 4'd3, 8'h00, 9'h080, 1'b0, 1'b0, 1'b0);
    chk_cyc("sub_t2", ST_T2, 4'd9, 8'h00, 9'h060, 1'b1, 1'b0, 1'b0);
    chk_cyc("sub_t3", ST_T3, 4'd11, 8'h08, 9'h000, 1'b0, 1'b1, 1'b0);
    fetch(16'hC805);
    chk_cyc("and_t1", ST_T1, 4'd4, 8'h00, 9'h080, 1'b0, 1'b0, 1'b0);
    chk_cyc("and_t2", ST_T2, 4'd5, 8'h00, 9'h050, 1'b1, 1'b0, 1'b0);
    bus.Run = 1'b0;
    chk_cyc("and_t3", ST_T3, 4'd11, 8'h10, 9'h000, 1'b0, 1'b1, 1'b0);
    chk0("and_idle", ST_IDLE, 1'b0);

    // mvt r2,#0x12
    start(); fetch(16'h3412);
    bus.Run = 1'b0;
    chk_cyc("mvt_t1", ST_T1, 4'd10, 8'h04, 9'h000, 1'b0, 1'b1, 1'b0);
    chk0("mvt_idle", ST_IDLE, 1'b0);

    // ld r5,[r6], four cycles in WAIT_D; Run drops mid-instruction
    start(); fetch(16'h8A06);
    bus.mem_ready = 1'b0; bus.Run = 1'b0;
    chk_cyc("ld_t1", ST_T1, 4'd6, 8'h00, 9'h008, 1'b0, 1'b0, 1'b0);
    for (int i = 0; i < 3; i++) chk0("ld_wait_d", ST_WAIT_D, 1'b0);
    bus.mem_ready = 1'b1;
    chk0("ld_wait_d_rdy", ST_WAIT_D, 1'b0);
    chk_cyc("ld_t3", ST_T3, 4'd8, 8'h20, 9'h000, 1'b0, 1'b1, 1'b0);
    chk0("ld_idle", ST_IDLE, 1'b0);

    // st r1,[r2]
    start(); fetch(16'hA202);
    bus.mem_ready = 1'b0;
    chk_cyc("st_t1", ST_T1, 4'd2, 8'h00, 9'h008, 1'b0, 1'b0, 1'b0);
    chk_cyc("st_t2", ST_T2, 4'd1, 8'h00, 9'h006, 1'b0, 1'b0, 1'b0);
    chk0("st_wait_d", ST_WAIT_D, 1'b0);
    bus.mem_ready = 1'b1; bus.Run = 1'b0;
    chk_cyc("st_done", ST_WAIT_D, 4'd0, 8'h00, 9'h000, 1'b0, 1'b1, 1'b0);
    chk0("st_idle", ST_IDLE, 1'b0);

    // slow fetch (10 cycles), then ld answered in the 15th (last) WAIT_D cycle
    start();
    bus.mem_ready = 1'b0;
    chk_cyc("fetch_slow", ST_FETCH, 4'd7, 8'h00, 9'h009, 1'b0, 1'b0, 1'b0);
    for (int i = 0; i < 10; i++) chk0("wait_i_slow", ST_WAIT_I, 1'b0);
    bus.mem_ready = 1'b1; bus.IR = 16'h8A06;
    chk_cyc("wait_i_rdy", ST_WAIT_I, 4'd0, 8'h00, 9'h100, 1'b0, 1'b0, 1'b0);
    bus.mem_ready = 1'b0; bus.Run = 1'b0;
    chk_cyc("ld2_t1", ST_T1, 4'd6, 8'h00, 9'h008, 1'b0, 1'b0, 1'b0);
    for (int i = 0; i < 14; i++) chk0("ld2_wait_d", ST_WAIT_D, 1'b0);
    bus.mem_ready = 1'b1;
    chk0("ld2_wait_d_last", ST_WAIT_D, 1'b0);
    chk_cyc("ld2_t3", ST_T3, 4'd8, 8'h20, 9'h000, 1'b0, 1'b1, 1'b0);
    chk0("ld2_idle", ST_IDLE, 1'b0);

    // ld never answered -> timeout after 15 cycles, ERR is sticky
    start(); fetch(16'h8A06);
    bus.mem_ready = 1'b0;
    chk_cyc("ld3_t1", ST_T1, 4'd6, 8'h00, 9'h008, 1'b0, 1'b0, 1'b0);
    for (int i = 0; i < 15; i++) chk0("to_wait_d", ST_WAIT_D, 1'b0);
    chk0("to_err", ST_ERR, 1'b1);
    bus.mem_ready = 1'b1; bus.Run = 1'b1;
    chk0("err_stuck", ST_ERR, 1'b1);
    chk0("err_stuck2", ST_ERR, 1'b1);
    resetn = 1'b0;
    chk0("err_rst", ST_IDLE, 1'b0);
    bus.Run = 1'b0; resetn = 1'b1;
    chk0("post_rst", ST_IDLE, 1'b0);

    // beq not taken (z=0), then beq taken (z=1), bmi not taken (n=0)
    bus.flags = 3'b000;
    start(); fetch(16'hE204);
    chk_cyc("beq_nt", ST_T1, 4'd0, 8'h00, 9'h000, 1'b0, 1'b1, 1'b0);
    bus.flags = 3'b001;
    fetch(16'hE204);
    chk_cyc("beq_t1", ST_T1, 4'd7, 8'h00, 9'h080, 1'b0, 1'b0, 1'b0);
    chk_cyc("beq_t2", ST_T2, 4'd9, 8'h00, 9'h040, 1'b0, 1'b0, 1'b0);
    chk_cyc("beq_t3", ST_T3, 4'd11, 8'h80, 9'h000, 1'b0, 1'b1, 1'b0);
    fetch(16'hEC04);
    chk_cyc("bmi_nt", ST_T1, 4'd0, 8'h00, 9'h000, 1'b0, 1'b1, 1'b0);

    // cond 7
    fetch(16'hEE04);
`ifdef PROC_CTRL_BL_EN
    chk_cyc("bl_t1", ST_T1, 4'd7, 8'h40, 9'h080, 1'b0, 1'b0, 1'b0);
    chk_cyc("bl_t2", ST_T2, 4'd9, 8'h00, 9'h040, 1'b0, 1'b0, 1'b0);
    bus.Run = 1'b0;
    chk_cyc("bl_t3", ST_T3, 4'd11, 8'h80, 9'h000, 1'b0, 1'b1, 1'b0);
`else
    bus.Run = 1'b0;
    chk_cyc("b7_nt", ST_T1, 4'd0, 8'h00, 9'h000, 1'b0, 1'b1, 1'b0);
`endif
    chk0("b_idle", ST_IDLE, 1'b0);

    // reset asserted mid-ld, between clock edges
    start(); fetch(16'h8A06);
    #1 resetn = 1'b0;
    chk0("rst_mid_ld", ST_IDLE, 1'b0);
    chk0("rst_held", ST_IDLE, 1'b0);
    bus.Run = 1'b0; resetn = 1'b1;
    chk0("rel_idle", ST_IDLE, 1'b0);
    chk0("rel_idle2", ST_IDLE, 1'b0);
    start();
    bus.Run = 1'b0;
    chk_cyc("rel_fetch", ST_FETCH, 4'd7, 8'h00, 9'h009, 1'b0, 1'b0, 1'b0);

    repeat (2) tick();
    checks++;
    if (sb_q.size() != 0) begin
      failures++;
      $display("FAIL sb_drain: got %0d pending entries, want 0", sb_q.size());
    end
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
